// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-compatible responder: opcode masks, DDRAM geometry,
// FSM states and the address-counter / display-offset stepping helpers.
package lcd_pkg;

   localparam logic [6:0] LINE1_BASE = 7'h00;
   localparam logic [6:0] LINE2_BASE = 7'h40;
   localparam int         LINE_LEN   = 40;
   localparam int         DDRAM_SIZE = 80;
   localparam logic [7:0] BLANK_CHAR = 8'h20;

   localparam logic [6:0] LINE1_LAST    = LINE1_BASE + 7'(LINE_LEN - 1);
   localparam logic [6:0] LINE2_LAST    = LINE2_BASE + 7'(LINE_LEN - 1);
   localparam logic [6:0] ONE_LINE_LAST = 7'(DDRAM_SIZE - 1);
   localparam logic [5:0] OFFSET_LAST   = 6'(LINE_LEN - 1);

   localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;
   localparam logic [7:0] CMD_SET_CGRAM  = 8'h40;
   localparam logic [7:0] CMD_FUNC_SET   = 8'h20;
   localparam logic [7:0] CMD_SHIFT      = 8'h10;
   localparam logic [7:0] CMD_DISP_CTRL  = 8'h08;
   localparam logic [7:0] CMD_ENTRY_MODE = 8'h04;
   localparam logic [7:0] CMD_HOME       = 8'h02;
   localparam logic [7:0] CMD_CLEAR      = 8'h01;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP,
      OP_CLEAR,
      OP_HOME,
      OP_ENTRY,
      OP_DISP,
      OP_SHIFT,
      OP_FUNC,
      OP_CGRAM,
      OP_DDRAM
   } op_t;

   // Highest set bit selects the instruction.
   function automatic op_t decode_op(input logic [7:0] b);
      op_t op;
      if      ((b & CMD_SET_DDRAM)  != 8'h00) op = OP_DDRAM;
      else if ((b & CMD_SET_CGRAM)  != 8'h00) op = OP_CGRAM;
      else if ((b & CMD_FUNC_SET)   != 8'h00) op = OP_FUNC;
      else if ((b & CMD_SHIFT)      != 8'h00) op = OP_SHIFT;
      else if ((b & CMD_DISP_CTRL)  != 8'h00) op = OP_DISP;
      else if ((b & CMD_ENTRY_MODE) != 8'h00) op = OP_ENTRY;
      else if ((b & CMD_HOME)       != 8'h00) op = OP_HOME;
      else if ((b & CMD_CLEAR)      != 8'h00) op = OP_CLEAR;
      else                                    op = OP_NOP;
      return op;
   endfunction

   // Out-of-range addresses (from set-address) fall back into the valid map on the next step.
   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc,
                                          input logic two_line);
      logic [6:0] nxt;
      if (two_line) begin
         if (inc) begin
            if (ac >= LINE2_LAST)                         nxt = LINE1_BASE;
            else if (ac >= LINE1_LAST && ac < LINE2_BASE) nxt = LINE2_BASE;
            else                                          nxt = ac + 7'd1;
         end else begin
            if (ac > LINE2_LAST)                          nxt = LINE1_BASE;
            else if (ac == LINE1_BASE)                    nxt = LINE2_LAST;
            else if (ac > LINE1_LAST && ac <= LINE2_BASE) nxt = LINE1_LAST;
            else                                          nxt = ac - 7'd1;
         end
      end else begin
         if (inc) begin
            if (ac >= ONE_LINE_LAST) nxt = LINE1_BASE;
            else                     nxt = ac + 7'd1;
         end else begin
            if (ac > ONE_LINE_LAST)    nxt = LINE1_BASE;
            else if (ac == LINE1_BASE) nxt = ONE_LINE_LAST;
            else                       nxt = ac - 7'd1;
         end
      end
      return nxt;
   endfunction

   function automatic logic [5:0] offset_step(input logic [5:0] off, input logic inc);
      logic [5:0] nxt;
      if (inc) nxt = (off >= OFFSET_LAST) ? 6'd0 : off + 6'd1;
      else     nxt = (off == 6'd0) ? OFFSET_LAST : off - 6'd1;
      return nxt;
   endfunction

   // Two-line mode packs line 2 (0x40..) directly after the 40 bytes of line 1.
   function automatic logic [6:0] ddram_index(input logic [6:0] addr, input logic two_line);
      logic [6:0] idx;
      if (two_line && addr[6]) idx = 7'(LINE_LEN) + {1'b0, addr[5:0]};
      else                     idx = addr;
      return idx;
   endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80-byte display data RAM: one synchronous write port, synchronous blank fill,
// combinational bus and debug read ports (out-of-range reads return a blank).
module lcd_ddram
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       fill,
   input  logic       we,
   input  logic [6:0] wr_idx,
   input  logic [7:0] wr_data,
   input  logic [6:0] bus_idx,
   output logic [7:0] bus_data,
   input  logic [6:0] dbg_idx,
   output logic [7:0] dbg_data
);

   logic [7:0] mem [DDRAM_SIZE];

   always_ff @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < DDRAM_SIZE; i++) mem[i] <= BLANK_CHAR;
      end else if (we && (wr_idx < 7'(DDRAM_SIZE))) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign bus_data = (bus_idx < 7'(DDRAM_SIZE)) ? mem[bus_idx] : BLANK_CHAR;
   assign dbg_data = (dbg_idx < 7'(DDRAM_SIZE)) ? mem[dbg_idx] : BLANK_CHAR;

endmodule

// File: rtl/lcd_responder.sv
// HD44780-compatible responder on the 8-bit LCD bus: decodes transfers on E falling edges,
// keeps DDRAM/AC/display flags and models busy timing. LCD_4BIT_MODE_EN adds nibble transfers.
//
// state | meaning
// IDLE  | ready, next command/data transfer is accepted
// BUSY  | executing, transfers other than status reads are dropped and set overrun
module lcd_responder
   import lcd_pkg::*;
#(
   parameter int BUSY_SHORT = 925,
   parameter int BUSY_LONG  = 38250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_e,
   input  logic [7:0] lcd_data_in,
   output logic [7:0] lcd_data_out,
   output logic       lcd_data_oe,
   output logic       busy,
   output logic       cmd_valid,
   output logic       cmd_rs,
   output logic       cmd_rw,
   output logic [7:0] cmd_byte,
   output logic [6:0] addr_counter,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic [5:0] display_offset,
   output logic       overrun,
   input  logic [6:0] dbg_addr,
   output logic [7:0] dbg_char
);

   localparam int CNT_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] LOAD_SHORT = CNT_W'(BUSY_SHORT - 1);
   localparam logic [CNT_W-1:0] LOAD_LONG  = CNT_W'(BUSY_LONG - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             e_q, rs_q, rw_q;
   logic [7:0]       data_q;
   logic             id_inc, shift_en, two_line;

`ifdef LCD_4BIT_MODE_EN
   logic             nib_mode, nib_phase;
   logic [3:0]       nib_hi;
`endif

   logic       fall;
   logic       xfer_valid, xfer_rs, xfer_rw;
   logic [7:0] xfer_byte;
   logic       is_status, accept, drop;
   logic       cmd_wr, data_wr, data_rd;
   op_t        op;
   logic [7:0] bus_char, rd_byte;

   assign fall = e_q & ~lcd_e;

   always_comb begin
      xfer_valid = fall;
      xfer_rs    = rs_q;
      xfer_rw    = rw_q;
      xfer_byte  = data_q;
`ifdef LCD_4BIT_MODE_EN
      // First nibble only completes a transfer when it is an 8-bit function set (DL=1).
      if (nib_mode && !nib_phase) xfer_valid = fall && !rs_q && !rw_q && (data_q[7:4] == 4'h3);
      else if (nib_mode)          xfer_byte  = {nib_hi, data_q[7:4]};
`endif
   end

   assign is_status = ~xfer_rs & xfer_rw;
   assign accept    = xfer_valid & ~is_status & (state == IDLE);
   assign drop      = xfer_valid & ~is_status & (state == BUSY);
   assign cmd_wr    = accept & ~xfer_rs & ~xfer_rw;
   assign data_wr   = accept & xfer_rs & ~xfer_rw;
   assign data_rd   = accept & xfer_rs & xfer_rw;
   assign op        = decode_op(xfer_byte);

   lcd_ddram u_ddram (
      .clk      (clk),
      .fill     (rst | (cmd_wr && op == OP_CLEAR)),
      .we       (data_wr),
      .wr_idx   (ddram_index(addr_counter, two_line)),
      .wr_data  (xfer_byte),
      .bus_idx  (ddram_index(addr_counter, two_line)),
      .bus_data (bus_char),
      .dbg_idx  (ddram_index(dbg_addr, two_line)),
      .dbg_data (dbg_char)
   );

   assign rd_byte     = lcd_rs ? bus_char : {busy, addr_counter};
   assign lcd_data_oe = lcd_e & lcd_rw;
`ifdef LCD_4BIT_MODE_EN
   always_comb begin
      lcd_data_out = 8'h00;
      if (lcd_data_oe) begin
         if (!nib_mode)      lcd_data_out = rd_byte;
         else if (nib_phase) lcd_data_out = {rd_byte[3:0], 4'h0};
         else                lcd_data_out = {rd_byte[7:4], 4'h0};
      end
   end
`else
   assign lcd_data_out = lcd_data_oe ? rd_byte : 8'h00;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         busy           <= 1'b0;
         e_q            <= 1'b0;
         rs_q           <= 1'b0;
         rw_q           <= 1'b0;
         data_q         <= 8'h00;
         cmd_valid      <= 1'b0;
         cmd_rs         <= 1'b0;
         cmd_rw         <= 1'b0;
         cmd_byte       <= 8'h00;
         addr_counter   <= 7'h00;
         id_inc         <= 1'b1;
         shift_en       <= 1'b0;
         two_line       <= 1'b0;
         display_on     <= 1'b0;
         cursor_on      <= 1'b0;
         blink_on       <= 1'b0;
         display_offset <= 6'd0;
         overrun        <= 1'b0;
`ifdef LCD_4BIT_MODE_EN
         nib_mode       <= 1'b0;
         nib_phase      <= 1'b0;
         nib_hi         <= 4'h0;
`endif
      end else begin
         e_q       <= lcd_e;
         rs_q      <= lcd_rs;
         rw_q      <= lcd_rw;
         data_q    <= lcd_data_in;
         cmd_valid <= accept;
         if (accept) begin
            cmd_rs   <= xfer_rs;
            cmd_rw   <= xfer_rw;
            cmd_byte <= data_rd ? bus_char : xfer_byte;
         end
         if (drop) overrun <= 1'b1;

         unique case (state)
            IDLE: begin
               if (accept) begin
                  state <= BUSY;
                  busy  <= 1'b1;
                  cnt   <= (cmd_wr && (op == OP_CLEAR || op == OP_HOME)) ? LOAD_LONG : LOAD_SHORT;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

`ifdef LCD_4BIT_MODE_EN
         if (nib_mode && fall) begin
            if (!nib_phase && !xfer_valid) begin
               nib_hi    <= data_q[7:4];
               nib_phase <= 1'b1;
            end else begin
               nib_phase <= 1'b0;
            end
         end
`endif

         if (data_wr) begin
            addr_counter <= ac_step(addr_counter, id_inc, two_line);
            if (shift_en) display_offset <= offset_step(display_offset, id_inc);
         end
         if (data_rd) addr_counter <= ac_step(addr_counter, id_inc, two_line);

         if (cmd_wr) begin
            unique case (op)
               OP_DDRAM: addr_counter <= xfer_byte[6:0];
               OP_FUNC: begin
                  two_line <= xfer_byte[3];
`ifdef LCD_4BIT_MODE_EN
                  nib_mode  <= ~xfer_byte[4];
                  nib_phase <= 1'b0;
`endif
               end
               OP_SHIFT: begin
                  if (xfer_byte[3]) display_offset <= offset_step(display_offset, xfer_byte[2]);
                  else              addr_counter   <= ac_step(addr_counter, xfer_byte[2], two_line);
               end
               OP_DISP: begin
                  display_on <= xfer_byte[2];
                  cursor_on  <= xfer_byte[1];
                  blink_on   <= xfer_byte[0];
               end
               OP_ENTRY: begin
                  id_inc   <= xfer_byte[1];
                  shift_en <= xfer_byte[0];
               end
               OP_HOME: begin
                  addr_counter   <= 7'h00;
                  display_offset <= 6'd0;
               end
               OP_CLEAR: begin
                  addr_counter   <= 7'h00;
                  id_inc         <= 1'b1;
                  display_offset <= 6'd0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/lcd_responder.md
Name: lcd_responder

Overview:
- Synthesizable HD44780-compatible character-display model: the responder end of the 8-bit LCD bus (RS, RW, E, DATA) driven by the SoC LCD controller.
- Decodes command/data transfers, maintains 80-byte DDRAM, address counter, display flags and busy flag; answers status and data reads.
- Used in system benches and the on-FPGA loopback self-test, so software LCD drivers can be checked against real busy/timing semantics.

Parameters:
- BUSY_SHORT, 925, busy cycles after any accepted command/data transfer except clear/home (37 us at 25 MHz).
- BUSY_LONG, 38250, busy cycles after clear display / return home (1.53 ms at 25 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- lcd_rs  in  1  register select (0 command/status, 1 data)
- lcd_rw  in  1  1 read, 0 write
- lcd_e  in  1  enable strobe, synchronous to clk
- lcd_data_in  in  8  bus data from controller
- lcd_data_out  out  8  read data
- lcd_data_oe  out  1  responder drives bus
- busy  out  1  busy flag
- cmd_valid  out  1  one-cycle pulse per accepted non-status transfer
- cmd_rs, cmd_rw  out  1 each  attributes of that transfer
- cmd_byte  out  8  byte written, or returned for a data read
- addr_counter  out  7  AC
- display_on, cursor_on, blink_on  out  1 each  display control flags
- display_offset  out  6  display shift, 0..39
- overrun  out  1  sticky: a transfer arrived while busy
- dbg_addr  in  7  DDRAM debug read address
- dbg_char  out  8  DDRAM[dbg_addr], combinational

Behaviour:
- Reset: DDRAM all 0x20; AC=0; I/D=1, S=0; N=0; display, cursor and blink off; offset 0; busy, overrun, cmd_valid, oe 0; data_out 0x00.
- Sampling: e_q, rs_q, rw_q, data_q registered every cycle. A transfer is a falling edge (e_q=1, lcd_e=0) and uses the *_q values. It commits on that clock edge; cmd_valid, AC, RAM and busy are visible the following cycle.
- Read drive: oe=1 whenever lcd_e=1 and lcd_rw=1. RS=0 drives {busy, AC}; RS=1 drives DDRAM[AC].
- FSM IDLE/BUSY:
  - Accepted command or data transfer: IDLE->BUSY, counter loaded with BUSY_SHORT, or BUSY_LONG for 0x01/0x02-0x03; busy=1 for exactly that many cycles, then IDLE.
  - Status read (RS=0, RW=1): always allowed, never starts busy, no cmd_valid.
- Transfer while BUSY, including on the last busy cycle: dropped, no cmd_valid, no state change, overrun=1 until reset. A data read while busy still drives bus data, but AC does not change.
- Commands, highest set bit wins:
  - 0x80|a: AC=a.
  - 0x40 (CGRAM): accepted, no effect.
  - 0x20 (function set): N=bit3; DL see option.
  - 0x10 (shift): S/C=bit3, R/L=bit2. S/C=0 moves AC ±1; S/C=1 changes offset ±1 mod 40.
  - 0x08: display=b2, cursor=b1, blink=b0.
  - 0x04: I/D=b1, S=b0.
  - 0x02: AC=0, offset=0.
  - 0x01: DDRAM all 0x20, AC=0, I/D=1, offset=0.
  - 0x00: no-op, but starts short busy.
- Data write: DDRAM[AC]=byte, then AC steps by I/D. If S=1, offset also steps by I/D (mod 40).
- Data read: AC steps by I/D at the falling edge.
- AC wrap:
  - N=1: 0x27+1->0x40, 0x67+1->0x00, 0x00-1->0x67, 0x40-1->0x27.
  - N=0: 0x4F+1->0x00, 0x00-1->0x4F.
  - Set-address values outside the valid range are stored as given; the next step re-enters the valid range via the same rules (above max -> 0x00).

Optional Feature:
- LCD_4BIT_MODE_EN defined: function set with DL=0 enters 4-bit mode. Each transfer is then two E strobes on data[7:4], high nibble first; a nibble flop pairs the strobes and the commit happens on the second. Status/data reads return the high nibble, then the low nibble. A function set with DL=1 received as a single strobe returns to 8-bit mode.
- Undefined: DL is ignored and the interface is always 8-bit.

Decomposition:
- Shared package lcd_pkg:
  - command opcode masks;
  - LINE1_BASE=0x00, LINE2_BASE=0x40, LINE_LEN=40, DDRAM_SIZE=80;
  - state enum {IDLE, BUSY};
  - address-step function implementing the wrap rules.
- Sub-module lcd_ddram: 80x8 register array, one synchronous write port, two combinational read ports (bus and debug), synchronous fill with 0x20.

Test Plan:
- Reset; BUSY_SHORT=4; status read -> 0x00. Write 0x38 -> cmd_valid, busy high exactly 4 cycles; status read during busy -> 0x80.
- Write 0x06, 0x80, then data 0x48, 0x69 -> dbg_char @0x00=0x48, @0x01=0x69; AC=0x02.
- N=1, set 0xA7 (AC=0x27), write 0x41 -> AC=0x40. Then I/D=0 (0x04), write 0x42 at 0x40 -> AC=0x27.
- BUSY_LONG=20; after a data write, 0x01 -> dbg_char @0x05=0x20, AC=0. Data written 10 cycles later is dropped, overrun=1.
- Set 0xC3, data read -> lcd_data_out=DDRAM[0x43] while E high, AC=0x44 after E falls. Assert rst mid-busy -> busy=0, AC=0, overrun=0.
- (LCD_4BIT_MODE_EN) Function set 0x28 as one strobe, then nibbles 0x4,0x1 as data -> DDRAM[AC]=0x41.
